axi_cmd_master: RTL and testbench
=================================

// Module: axi_cmd_master
// PURPOSE
//  Synthesizable AXI3 initiator: drives the slave-side interface of the axi2apb bridge.
//  Converts one command (addr/len/size/burst/id) into a full AXI read or write transaction.
//  Streams write beats in and read beats out; reports one completion per command.
//  One transaction outstanding at a time; used as bus driver in the bridge subsystem.
// PARAMETERS
//  C_AXI_ID_WIDTH    5    AWID/WID/BID/ARID/RID width
//  C_AXI_ADDR_WIDTH  32   address width
//  C_AXI_DATA_WIDTH  64   data width; C_AXI_STRB_WIDTH = C_AXI_DATA_WIDTH/8
//  C_AXI_LEN_WIDTH   4    burst length field (beats = LEN+1, max 16)
//  C_TIMEOUT         1024 max cycles waiting in any AXI handshake state before abort
// PORTS
//  AXI_ACLK in 1 sole clock | AXI_ARESET in 1 synchronous reset, active-high
//  cmd_valid/cmd_ready in/out 1 command handshake | cmd_write in 1 1=write 0=read
//  cmd_addr in ADDR | cmd_len in LEN | cmd_size in 3 | cmd_burst in 2 | cmd_id in ID
//  wr_data in DATA | wr_strb in STRB | wr_valid in 1 | wr_ready out 1 write beat stream
//  rd_data out DATA | rd_resp out 2 | rd_last out 1 | rd_valid out 1 | rd_ready in 1
//  done_valid out 1 one-cycle completion pulse | done_id out ID | done_resp out 2
//  done_err out 3 {timeout, id_mismatch, last_mismatch}; 4KB-cross reject reported as done_resp=SLVERR, done_err=0
//  AXI_AW*: AWID AWADDR AWREG(4,=0) AWLEN AWSIZE AWBURST AWLOCK(2,=0) AWCACHE(4,=0) AWPROT(3,=0) AWQOS(4,=0) AWVALID out, AWREADY in
//  AXI_W*: WID WDATA WSTRB WLAST WVALID out, WREADY in | AXI_B*: BID BRESP BVALID in, BREADY out
//  AXI_AR*: mirror of AW* out, ARREADY in | AXI_R*: RID RDATA RRESP RLAST RVALID in, RREADY out
// BEHAVIOUR
//  Reset (sync, AXI_ARESET=1 at posedge): state IDLE; all VALID/READY outputs 0; done_* 0;
//   counters 0; in-flight transaction abandoned, no done pulse. Applies mid-burst too.
//  FSM: IDLE -> WR_ADDR|RD_ADDR -> WR_DATA -> WR_RESP | RD_DATA -> DONE -> IDLE.
//  IDLE: cmd_ready=1. On cmd_valid: latch cmd; if burst==INCR and
//   addr[11:0] + ((len+1)<<size) > 4096 -> DONE with SLVERR (no bus activity).
//  WR_ADDR/RD_ADDR: xVALID=1 registered, fields stable until xREADY; then advance.
//  WR_DATA: W channel is pass-through: WVALID=wr_valid, wr_ready=WREADY, WID=latched id;
//   WLAST=(beat_cnt==len); beat_cnt++ per W handshake; last handshake -> WR_RESP.
//  WR_RESP: BREADY=1. On BVALID: done_resp=BRESP; id_mismatch if BID!=latched id.
//  RD_DATA: RREADY=rd_ready; rd_* = R* combinational; per handshake beat_cnt++,
//   sticky resp = max(resp) (DECERR>SLVERR>OKAY). RLAST early or absent on final beat ->
//   last_mismatch; exit on RLAST handshake or beat len handshake, whichever first.
//  DONE: done_valid=1 for exactly one cycle, then IDLE (cmd_ready=1 next cycle).
//  Latency: cmd accept -> AWVALID/ARVALID = 1 cycle; final B/R handshake -> done_valid = 1 cycle.
//  Timeout: cycle counter reset on every state change/handshake; reaching C_TIMEOUT in
//   ADDR/DATA/RESP state -> drop all VALIDs, done with SLVERR + timeout bit.
//  FIXED/WRAP bursts pass through unchecked (no 4KB test); WRAP len must be 1,3,7,15 (caller's duty).
// STRUCTURE
//  Package axi_master_pkg: state enum, RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_FIXED/INCR/WRAP,
//   done_err bit indices, resp-severity compare function.
//  Sub-module axi_beat_counter: load len, increment on handshake, flag is_last; used for W and R.
// TESTING
//  Write len=3 size=3 addr=0x1000 id=5, AWREADY=1 -> 4 W beats, WLAST on 4th, BRESP=0 -> done_resp=0, done_err=0.
//  Read len=0 addr=0x2008, RDATA=0xDEADBEEF_CAFEF00D RLAST=1 -> one rd beat, done_resp=0.
//  Read len=3, 3rd beat RRESP=2 (SLVERR), RID=5 -> done_resp=2; RID=6 on one beat -> done_err=3'b010.
//  INCR write addr=0x0FF8 len=1 size=3 (crosses 4KB) -> no AWVALID, done_resp=2 next cycle.
//  AWREADY held 0 for C_TIMEOUT cycles -> AWVALID drops, done_err=3'b100, done_resp=2.
//  Reset asserted during beat 2 of len=7 write -> next cycle all VALID=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/axi_master_pkg.sv
// Shared types and helpers for the AXI3 command master: FSM states, response and
// burst encodings, completion-error bit positions, response severity and 4KB checks.
package axi_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_RD_ADDR = 3'd2,
      ST_WR_DATA = 3'd3,
      ST_WR_RESP = 3'd4,
      ST_RD_DATA = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam int ERR_LAST_MISMATCH = 0;
   localparam int ERR_ID_MISMATCH   = 1;
   localparam int ERR_TIMEOUT       = 2;

   // Response encodings already ascend in severity (OKAY < EXOKAY < SLVERR < DECERR).
   function automatic logic [1:0] resp_worse(input logic [1:0] a, input logic [1:0] b);
      return (b > a) ? b : a;
   endfunction

   // True when an INCR burst starting at this page offset runs past the 4KB boundary.
   function automatic logic crosses_4k(input logic [11:0] offset,
                                       input logic [7:0]  len,
                                       input logic [2:0]  size);
      logic [16:0] span;
      span = (17'(len) + 17'd1) << size;
      return (17'(offset) + span) > 17'd4096;
   endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter for one burst: loaded with LEN at command accept, advanced per
// data handshake, flags the final beat.
module axi_beat_counter
   import axi_master_pkg::*;
#(
   parameter int C_AXI_LEN_WIDTH = 4
) (
   input  logic                       AXI_ACLK,
   input  logic                       AXI_ARESET,
   input  logic                       load,
   input  logic [C_AXI_LEN_WIDTH-1:0] len,
   input  logic                       inc,
   output logic                       is_last
);

   logic [C_AXI_LEN_WIDTH-1:0] count_q;
   logic [C_AXI_LEN_WIDTH-1:0] len_q;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) begin
         count_q <= '0;
         len_q   <= '0;
      end else if (load) begin
         count_q <= '0;
         len_q   <= len;
      end else if (inc) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign is_last = (count_q == len_q);

endmodule

// File: rtl/axi_cmd_master.sv
// AXI3 initiator: turns one command into a complete read or write burst,
// streams beats through, and reports a single completion per command.
module axi_cmd_master
   import axi_master_pkg::*;
#(
   parameter int C_AXI_ID_WIDTH   = 5,
   parameter int C_AXI_ADDR_WIDTH = 32,
   parameter int C_AXI_DATA_WIDTH = 64,
   parameter int C_AXI_LEN_WIDTH  = 4,
   parameter int C_TIMEOUT        = 1024
) (
   input  logic                          AXI_ACLK,
   input  logic                          AXI_ARESET,
   // command
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_AXI_LEN_WIDTH-1:0]    cmd_len,
   input  logic [2:0]                    cmd_size,
   input  logic [1:0]                    cmd_burst,
   input  logic [C_AXI_ID_WIDTH-1:0]     cmd_id,
   // write beat stream
   input  logic [C_AXI_DATA_WIDTH-1:0]   wr_data,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] wr_strb,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   // read beat stream
   output logic [C_AXI_DATA_WIDTH-1:0]   rd_data,
   output logic [1:0]                    rd_resp,
   output logic                          rd_last,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   // completion
   output logic                          done_valid,
   output logic [C_AXI_ID_WIDTH-1:0]     done_id,
   output logic [1:0]                    done_resp,
   output logic [2:0]                    done_err,
   // AW channel
   output logic [C_AXI_ID_WIDTH-1:0]     AXI_AWID,
   output logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
   output logic [3:0]                    AXI_AWREG,
   output logic [C_AXI_LEN_WIDTH-1:0]    AXI_AWLEN,
   output logic [2:0]                    AXI_AWSIZE,
   output logic [1:0]                    AXI_AWBURST,
   output logic [1:0]                    AXI_AWLOCK,
   output logic [3:0]                    AXI_AWCACHE,
   output logic [2:0]                    AXI_AWPROT,
   output logic [3:0]                    AXI_AWQOS,
   output logic                          AXI_AWVALID,
   input  logic                          AXI_AWREADY,
   // W channel
   output logic [C_AXI_ID_WIDTH-1:0]     AXI_WID,
   output logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
   output logic [C_AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
   output logic                          AXI_WLAST,
   output logic                          AXI_WVALID,
   input  logic                          AXI_WREADY,
   // B channel
   input  logic [C_AXI_ID_WIDTH-1:0]     AXI_BID,
   input  logic [1:0]                    AXI_BRESP,
   input  logic                          AXI_BVALID,
   output logic                          AXI_BREADY,
   // AR channel
   output logic [C_AXI_ID_WIDTH-1:0]     AXI_ARID,
   output logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
   output logic [3:0]                    AXI_ARREG,
   output logic [C_AXI_LEN_WIDTH-1:0]    AXI_ARLEN,
   output logic [2:0]                    AXI_ARSIZE,
   output logic [1:0]                    AXI_ARBURST,
   output logic [1:0]                    AXI_ARLOCK,
   output logic [3:0]                    AXI_ARCACHE,
   output logic [2:0]                    AXI_ARPROT,
   output logic [3:0]                    AXI_ARQOS,
   output logic                          AXI_ARVALID,
   input  logic                          AXI_ARREADY,
   // R channel
   input  logic [C_AXI_ID_WIDTH-1:0]     AXI_RID,
   input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
   input  logic [1:0]                    AXI_RRESP,
   input  logic                          AXI_RLAST,
   input  logic                          AXI_RVALID,
   output logic                          AXI_RREADY
);

   localparam int TMO_W = $clog2(C_TIMEOUT + 1);

   state_t                        state_q, state_d;
   logic [C_AXI_ADDR_WIDTH-1:0]   addr_q;
   logic [C_AXI_LEN_WIDTH-1:0]    len_q;
   logic [2:0]                    size_q;
   logic [1:0]                    burst_q;
   logic [C_AXI_ID_WIDTH-1:0]     id_q;
   logic [1:0]                    resp_q;
   logic [2:0]                    err_q;
   logic [TMO_W-1:0]              tmo_q;

   logic cmd_hs, cross_4k, hs, waiting, tmo_hit, beat_inc, last_beat;
   logic w_hs, r_hs;

   assign cmd_hs   = cmd_valid && (state_q == ST_IDLE);
   assign cross_4k = (cmd_burst == BURST_INCR) &&
                     crosses_4k(cmd_addr[11:0], 8'(cmd_len), cmd_size);
   assign w_hs     = (state_q == ST_WR_DATA) && wr_valid && AXI_WREADY;
   assign r_hs     = (state_q == ST_RD_DATA) && AXI_RVALID && rd_ready;
   assign beat_inc = w_hs || r_hs;

   axi_beat_counter #(
      .C_AXI_LEN_WIDTH (C_AXI_LEN_WIDTH)
   ) u_beat_counter (
      .AXI_ACLK   (AXI_ACLK),
      .AXI_ARESET (AXI_ARESET),
      .load       (cmd_hs),
      .len        (cmd_len),
      .inc        (beat_inc),
      .is_last    (last_beat)
   );

   // State register
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // Next-state logic; also exposes the handshake and timeout events to the datapath.
   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      hs      = 1'b0;
      waiting = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cross_4k)       state_d = ST_DONE;
               else if (cmd_write) state_d = ST_WR_ADDR;
               else                state_d = ST_RD_ADDR;
            end
         end
         ST_WR_ADDR: begin
            waiting = 1'b1;
            hs      = AXI_AWREADY;
            if (hs) state_d = ST_WR_DATA;
         end
         ST_RD_ADDR: begin
            waiting = 1'b1;
            hs      = AXI_ARREADY;
            if (hs) state_d = ST_RD_DATA;
         end
         ST_WR_DATA: begin
            waiting = 1'b1;
            hs      = w_hs;
            if (hs && last_beat) state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            waiting = 1'b1;
            hs      = AXI_BVALID;
            if (hs) state_d = ST_DONE;
         end
         ST_RD_DATA: begin
            waiting = 1'b1;
            hs      = r_hs;
            if (hs && (AXI_RLAST || last_beat)) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      tmo_hit = waiting && !hs && (tmo_q == TMO_W'(C_TIMEOUT - 1));
      if (tmo_hit) state_d = ST_DONE;
   end

   // Command latch, completion status and handshake watchdog
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) begin
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         id_q    <= '0;
         resp_q  <= RESP_OKAY;
         err_q   <= '0;
         tmo_q   <= '0;
      end else begin
         if (hs || (state_d != state_q)) tmo_q <= '0;
         else if (waiting)               tmo_q <= tmo_q + 1'b1;

         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  len_q   <= cmd_len;
                  size_q  <= cmd_size;
                  burst_q <= cmd_burst;
                  id_q    <= cmd_id;
                  resp_q  <= cross_4k ? RESP_SLVERR : RESP_OKAY;
                  err_q   <= '0;
               end
            end
            ST_WR_RESP: begin
               if (AXI_BVALID) begin
                  resp_q                 <= AXI_BRESP;
                  err_q[ERR_ID_MISMATCH] <= (AXI_BID != id_q);
               end
            end
            ST_RD_DATA: begin
               if (r_hs) begin
                  resp_q <= resp_worse(resp_q, AXI_RRESP);
                  if (AXI_RID != id_q)        err_q[ERR_ID_MISMATCH]   <= 1'b1;
                  if (AXI_RLAST != last_beat) err_q[ERR_LAST_MISMATCH] <= 1'b1;
               end
            end
            default: ;
         endcase

         if (tmo_hit) begin
            resp_q             <= RESP_SLVERR;
            err_q[ERR_TIMEOUT] <= 1'b1;
         end
      end
   end

   // Handshake and completion outputs, decoded from the registered state
   always_comb begin
      cmd_ready   = 1'b0;
      AXI_AWVALID = 1'b0;
      AXI_ARVALID = 1'b0;
      AXI_WVALID  = 1'b0;
      AXI_WLAST   = 1'b0;
      wr_ready    = 1'b0;
      AXI_BREADY  = 1'b0;
      AXI_RREADY  = 1'b0;
      rd_valid    = 1'b0;
      done_valid  = 1'b0;
      done_id     = '0;
      done_resp   = RESP_OKAY;
      done_err    = '0;
      unique case (state_q)
         ST_IDLE:    cmd_ready   = 1'b1;
         ST_WR_ADDR: AXI_AWVALID = 1'b1;
         ST_RD_ADDR: AXI_ARVALID = 1'b1;
         ST_WR_DATA: begin
            AXI_WVALID = wr_valid;
            AXI_WLAST  = last_beat;
            wr_ready   = AXI_WREADY;
         end
         ST_WR_RESP: AXI_BREADY = 1'b1;
         ST_RD_DATA: begin
            AXI_RREADY = rd_ready;
            rd_valid   = AXI_RVALID;
         end
         ST_DONE: begin
            done_valid = 1'b1;
            done_id    = id_q;
            done_resp  = resp_q;
            done_err   = err_q;
         end
         default: ;
      endcase
   end

   // Address channels share the latched command; unused sideband fields tie low.
   assign AXI_AWID    = id_q;
   assign AXI_AWADDR  = addr_q;
   assign AXI_AWREG   = 4'd0;
   assign AXI_AWLEN   = len_q;
   assign AXI_AWSIZE  = size_q;
   assign AXI_AWBURST = burst_q;
   assign AXI_AWLOCK  = 2'd0;
   assign AXI_AWCACHE = 4'd0;
   assign AXI_AWPROT  = 3'd0;
   assign AXI_AWQOS   = 4'd0;

   assign AXI_ARID    = id_q;
   assign AXI_ARADDR  = addr_q;
   assign AXI_ARREG   = 4'd0;
   assign AXI_ARLEN   = len_q;
   assign AXI_ARSIZE  = size_q;
   assign AXI_ARBURST = burst_q;
   assign AXI_ARLOCK  = 2'd0;
   assign AXI_ARCACHE = 4'd0;
   assign AXI_ARPROT  = 3'd0;
   assign AXI_ARQOS   = 4'd0;

   assign AXI_WID   = id_q;
   assign AXI_WDATA = wr_data;
   assign AXI_WSTRB = wr_strb;

   assign rd_data = AXI_RDATA;
   assign rd_resp = AXI_RRESP;
   assign rd_last = AXI_RLAST;

endmodule

// File: tb/tb_axi_cmd_master.sv
// Directed bench for axi_cmd_master: write/read bursts, response merging,
// ID/RLAST errors, 4KB reject, handshake timeout and mid-burst reset.
module tb_axi_cmd_master;
   import axi_master_pkg::*;

   localparam int TMO = 32;

   logic        AXI_ACLK = 1'b0;
   logic        AXI_ARESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic [1:0]  cmd_burst;
   logic [4:0]  cmd_id;
   logic [63:0] wr_data;
   logic [7:0]  wr_strb;
   logic        wr_valid, wr_ready;
   logic [63:0] rd_data;
   logic [1:0]  rd_resp;
   logic        rd_last, rd_valid, rd_ready;
   logic        done_valid;
   logic [4:0]  done_id;
   logic [1:0]  done_resp;
   logic [2:0]  done_err;
   logic [4:0]  AXI_AWID, AXI_ARID, AXI_WID, AXI_BID, AXI_RID;
   logic [31:0] AXI_AWADDR, AXI_ARADDR;
   logic [3:0]  AXI_AWREG, AXI_AWCACHE, AXI_AWQOS, AXI_ARREG, AXI_ARCACHE, AXI_ARQOS;
   logic [3:0]  AXI_AWLEN, AXI_ARLEN;
   logic [2:0]  AXI_AWSIZE, AXI_AWPROT, AXI_ARSIZE, AXI_ARPROT;
   logic [1:0]  AXI_AWBURST, AXI_AWLOCK, AXI_ARBURST, AXI_ARLOCK;
   logic        AXI_AWVALID, AXI_AWREADY, AXI_ARVALID, AXI_ARREADY;
   logic [63:0] AXI_WDATA, AXI_RDATA;
   logic [7:0]  AXI_WSTRB;
   logic        AXI_WLAST, AXI_WVALID, AXI_WREADY;
   logic [1:0]  AXI_BRESP, AXI_RRESP;
   logic        AXI_BVALID, AXI_BREADY;
   logic        AXI_RLAST, AXI_RVALID, AXI_RREADY;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 AXI_ACLK = ~AXI_ACLK;

   axi_cmd_master #(
      .C_AXI_ID_WIDTH (5), .C_AXI_ADDR_WIDTH (32), .C_AXI_DATA_WIDTH (64),
      .C_AXI_LEN_WIDTH (4), .C_TIMEOUT (TMO)
   ) dut (
      .AXI_ACLK (AXI_ACLK), .AXI_ARESET (AXI_ARESET),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
      .cmd_addr (cmd_addr), .cmd_len (cmd_len), .cmd_size (cmd_size),
      .cmd_burst (cmd_burst), .cmd_id (cmd_id),
      .wr_data (wr_data), .wr_strb (wr_strb), .wr_valid (wr_valid), .wr_ready (wr_ready),
      .rd_data (rd_data), .rd_resp (rd_resp), .rd_last (rd_last), .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .done_valid (done_valid), .done_id (done_id), .done_resp (done_resp), .done_err (done_err),
      .AXI_AWID (AXI_AWID), .AXI_AWADDR (AXI_AWADDR), .AXI_AWREG (AXI_AWREG),
      .AXI_AWLEN (AXI_AWLEN), .AXI_AWSIZE (AXI_AWSIZE), .AXI_AWBURST (AXI_AWBURST),
      .AXI_AWLOCK (AXI_AWLOCK), .AXI_AWCACHE (AXI_AWCACHE), .AXI_AWPROT (AXI_AWPROT),
      .AXI_AWQOS (AXI_AWQOS), .AXI_AWVALID (AXI_AWVALID), .AXI_AWREADY (AXI_AWREADY),
      .AXI_WID (AXI_WID), .AXI_WDATA (AXI_WDATA), .AXI_WSTRB (AXI_WSTRB),
      .AXI_WLAST (AXI_WLAST), .AXI_WVALID (AXI_WVALID), .AXI_WREADY (AXI_WREADY),
      .AXI_BID (AXI_BID), .AXI_BRESP (AXI_BRESP), .AXI_BVALID (AXI_BVALID),
      .AXI_BREADY (AXI_BREADY),
      .AXI_ARID (AXI_ARID), .AXI_ARADDR (AXI_ARADDR), .AXI_ARREG (AXI_ARREG),
      .AXI_ARLEN (AXI_ARLEN), .AXI_ARSIZE (AXI_ARSIZE), .AXI_ARBURST (AXI_ARBURST),
      .AXI_ARLOCK (AXI_ARLOCK), .AXI_ARCACHE (AXI_ARCACHE), .AXI_ARPROT (AXI_ARPROT),
      .AXI_ARQOS (AXI_ARQOS), .AXI_ARVALID (AXI_ARVALID), .AXI_ARREADY (AXI_ARREADY),
      .AXI_RID (AXI_RID), .AXI_RDATA (AXI_RDATA), .AXI_RRESP (AXI_RRESP),
      .AXI_RLAST (AXI_RLAST), .AXI_RVALID (AXI_RVALID), .AXI_RREADY (AXI_RREADY)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Lands 1 time unit after the rising edge; inputs change here, checks follow a further #1.
   task automatic step();
      @(posedge AXI_ACLK);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input logic [4:0] id);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      cmd_size = size; cmd_burst = burst; cmd_id = id;
      #1 check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic check_done(input string tag, input logic [4:0] id,
                             input logic [1:0] resp, input logic [2:0] err);
      check({tag, "_done_valid"}, 64'(done_valid), 64'd1);
      check({tag, "_done_id"},    64'(done_id),    64'(id));
      check({tag, "_done_resp"},  64'(done_resp),  64'(resp));
      check({tag, "_done_err"},   64'(done_err),   64'(err));
      step();
      #1;
      check({tag, "_done_pulse_end"}, 64'(done_valid), 64'd0);
      check({tag, "_cmd_ready_back"}, 64'(cmd_ready),  64'd1);
   endtask

   // Read burst, size 3; resps packs 2 bits per beat, RID corrupted on bad_id_beat, RLAST on last_at.
   task automatic run_read(input logic [31:0] addr, input logic [3:0] len, input logic [4:0] id,
                           input logic [63:0] dbase, input logic [7:0] resps,
                           input int bad_id_beat, input int last_at);
      issue(1'b0, addr, len, 3'd3, BURST_INCR, id);
      #1;
      check("ar_valid", 64'(AXI_ARVALID), 64'd1);
      check("ar_addr",  64'(AXI_ARADDR),  64'(addr));
      check("ar_len",   64'(AXI_ARLEN),   64'(len));
      AXI_ARREADY = 1'b1;
      step();
      AXI_ARREADY = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         AXI_RVALID = 1'b1;
         AXI_RID    = (b == bad_id_beat) ? id + 5'd1 : id;
         AXI_RRESP  = resps[2*b +: 2];
         AXI_RLAST  = (b == last_at);
         AXI_RDATA  = dbase + 64'(b);
         #1;
         check("rd_valid", 64'(rd_valid), 64'd1);
         check("rd_data",  64'(rd_data),  dbase + 64'(b));
         step();
         if (b == last_at) break;
      end
      AXI_RVALID = 1'b0;
      AXI_RLAST  = 1'b0;
      #1;
   endtask

   initial begin
      int n_aw;
      int pulses;
      AXI_ARESET = 1'b1;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
      cmd_burst = 0; cmd_id = 0;
      wr_data = 0; wr_strb = 8'hFF; wr_valid = 0; rd_ready = 1'b1;
      AXI_AWREADY = 0; AXI_ARREADY = 0; AXI_WREADY = 0;
      AXI_BID = 0; AXI_BRESP = 0; AXI_BVALID = 0;
      AXI_RID = 0; AXI_RDATA = 0; AXI_RRESP = 0; AXI_RLAST = 0; AXI_RVALID = 0;
      repeat (3) step();
      AXI_ARESET = 1'b0;
      #1;
      check("rst_cmd_ready",  64'(cmd_ready),   64'd1);
      check("rst_awvalid",    64'(AXI_AWVALID), 64'd0);
      check("rst_arvalid",    64'(AXI_ARVALID), 64'd0);
      check("rst_rready",     64'(AXI_RREADY),  64'd0);
      check("rst_done_valid", 64'(done_valid),  64'd0);

      // Write len=3 size=3 @0x1000 id=5, one wr_valid bubble before beat 2
      issue(1'b1, 32'h1000, 4'd3, 3'd3, BURST_INCR, 5'd5);
      AXI_AWREADY = 1'b1;
      #1;
      check("wr_awvalid", 64'(AXI_AWVALID), 64'd1);
      check("wr_awaddr",  64'(AXI_AWADDR),  64'h1000);
      check("wr_awlen",   64'(AXI_AWLEN),   64'd3);
      check("wr_awid",    64'(AXI_AWID),    64'd5);
      check("wr_awburst", 64'(AXI_AWBURST), 64'(BURST_INCR));
      step();
      AXI_AWREADY = 1'b0;
      AXI_WREADY  = 1'b1;
      #1 check("wr_awvalid_drop", 64'(AXI_AWVALID), 64'd0);
      for (int b = 0; b < 4; b++) begin
         if (b == 2) begin
            wr_valid = 1'b0;
            #1 check("wr_bubble_wvalid", 64'(AXI_WVALID), 64'd0);
            step();
         end
         wr_valid = 1'b1;
         wr_data  = 64'hA000 + 64'(b);
         #1;
         check("wr_wvalid", 64'(AXI_WVALID), 64'd1);
         check("wr_wdata",  64'(AXI_WDATA),  64'hA000 + 64'(b));
         check("wr_wlast",  64'(AXI_WLAST),  64'(b == 3));
         check("wr_wid",    64'(AXI_WID),    64'd5);
         step();
      end
      wr_valid = 1'b0;
      #1;
      check("wr_bready", 64'(AXI_BREADY), 64'd1);
      check("wr_wvalid_after", 64'(AXI_WVALID), 64'd0);
      AXI_BVALID = 1'b1; AXI_BID = 5'd5; AXI_BRESP = RESP_OKAY;
      step();
      AXI_BVALID = 1'b0;
      #1 check_done("wr", 5'd5, RESP_OKAY, 3'b000);

      // Single-beat read
      run_read(32'h2008, 4'd0, 5'd3, 64'hDEADBEEF_CAFEF00D, 8'h00, -1, 0);
      check_done("rd1", 5'd3, RESP_OKAY, 3'b000);

      // SLVERR on beat 2 dominates the merged response
      run_read(32'h3000, 4'd3, 5'd5, 64'h5000, {2'b00, RESP_SLVERR, 2'b00, 2'b00}, -1, 3);
      check_done("rd_slverr", 5'd5, RESP_SLVERR, 3'b000);

      // Wrong RID on beat 1
      run_read(32'h3000, 4'd3, 5'd5, 64'h6000, 8'h00, 1, 3);
      check_done("rd_badid", 5'd5, RESP_OKAY, 3'b010);

      // Early RLAST on beat 1 of 4 ends the burst with last_mismatch
      run_read(32'h3000, 4'd3, 5'd7, 64'h7000, {RESP_OKAY, RESP_OKAY, RESP_DECERR, RESP_OKAY}, -1, 1);
      check_done("rd_early_last", 5'd7, RESP_DECERR, 3'b001);

      // Ends exactly at the 4KB boundary: accepted
      run_read(32'h0FF0, 4'd1, 5'd2, 64'h8000, 8'h00, -1, 1);
      check_done("rd_edge4k", 5'd2, RESP_OKAY, 3'b000);

      // Crosses 4KB: rejected with no bus activity
      issue(1'b1, 32'h0FF8, 4'd1, 3'd3, BURST_INCR, 5'd9);
      #1;
      check("x4k_awvalid", 64'(AXI_AWVALID), 64'd0);
      check_done("x4k", 5'd9, RESP_SLVERR, 3'b000);

      // AWREADY never arrives: AWVALID held exactly TMO cycles, then timeout completion
      issue(1'b1, 32'h0100, 4'd0, 3'd3, BURST_INCR, 5'd4);
      n_aw = 0;
      for (int i = 0; i < 4 * TMO; i++) begin
         #1;
         if (done_valid) break;
         if (AXI_AWVALID) n_aw++;
         step();
      end
      check("tmo_awvalid_cycles", 64'(n_aw), 64'(TMO));
      check("tmo_awvalid_drop", 64'(AXI_AWVALID), 64'd0);
      check_done("tmo", 5'd4, RESP_SLVERR, 3'b100);

      // Reset during beat 2 of a len=7 write
      issue(1'b1, 32'h4000, 4'd7, 3'd3, BURST_INCR, 5'd1);
      AXI_AWREADY = 1'b1;
      step();
      AXI_AWREADY = 1'b0;
      wr_valid = 1'b1;
      step();
      step();
      #1 check("rst_mid_wvalid_before", 64'(AXI_WVALID), 64'd1);
      AXI_ARESET = 1'b1;
      step();
      AXI_ARESET = 1'b0;
      #1;
      check("rst_mid_wvalid",    64'(AXI_WVALID),  64'd0);
      check("rst_mid_awvalid",   64'(AXI_AWVALID), 64'd0);
      check("rst_mid_bready",    64'(AXI_BREADY),  64'd0);
      check("rst_mid_cmd_ready", 64'(cmd_ready),   64'd1);
      wr_valid = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (done_valid) pulses++;
         step();
      end
      check("rst_mid_no_done", 64'(pulses), 64'd0);

      // Fresh command after the abandoned burst
      run_read(32'h5000, 4'd0, 5'd6, 64'h9000, 8'h00, -1, 0);
      check_done("rd_after_rst", 5'd6, RESP_OKAY, 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
